imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Arbitrates the single-ported instruction RAM at byte region 0xC000_0000 between two requesters: the CPU fetch stage and the CPU store path. The boot program copies code into this region with `sw` and then jumps into it. Stores take priority so that a fetch issued after a store always sees the new data. A burst limiter guarantees fetch forward progress. The block sits between the datapath (fetch and memory stages) and the synchronous-read instruction RAM.

## Interface
Parameters:
- ADDR_W, 12, RAM word-address width (RAM depth 2^ADDR_W words)
- REGION, 4'hC, required value of word-address bits [29:26] for a store to be accepted
- MAX_ST_BURST, 4, maximum consecutive store grants while a fetch is waiting (range 1..15)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- if_req  in  1  fetch request
- if_addr  in  30  fetch word address (RAM uses bits [ADDR_W-1:0])
- if_flush  in  1  cancel fetch data returning this cycle
- if_gnt  out  1  fetch granted this cycle (combinational)
- if_rvalid  out  1  fetch data valid
- if_rdata  out  32  fetch data (direct pass-through of mem_rdata)
- st_req  in  1  store request
- st_addr  in  30  store word address
- st_wdata  in  32  store data
- st_be  in  4  byte enables
- st_gnt  out  1  store consumed this cycle (combinational)
- st_err  out  1  registered one-cycle pulse: the store was outside REGION and was dropped
- mem_en  out  1  RAM enable
- mem_we  out  4  RAM byte write enables
- mem_addr  out  ADDR_W  RAM word address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid the cycle after a read enable

## Operation
Grant (combinational, single cycle):
- Store only (`st_req`=1, `if_req`=0): `st_gnt`=1.
- Fetch only: `if_gnt`=1.
- Both requesting: store wins unless `run`==MAX_ST_BURST; in that case fetch wins.
- Never both grants in one cycle.

Store path:
- In REGION (`st_addr[29:26]`==REGION): `mem_en`=1, `mem_we`=`st_be`, `mem_addr`=`st_addr[ADDR_W-1:0]`, `mem_wdata`=`st_wdata`.
- Out of REGION: `st_gnt`=1, `mem_we`=0, `mem_en`=0, `st_err`=1 the next cycle.
- `st_be`=0 in REGION: counts as a grant with no write (`mem_en`=1, `mem_we`=0, no `st_err`).

Fetch path:
- `mem_en`=1, `mem_we`=0, `mem_addr`=`if_addr[ADDR_W-1:0]`.
- Pending flag `pend` is set by the grant and is live the next cycle.

Burst counter `run` (4 bits):
- Increments on each store grant while `if_req`=1.
- Clears on a fetch grant or any cycle with `if_req`=0.
- Saturates at MAX_ST_BURST.

Idle: `mem_en`=0, `mem_we`=0; `mem_addr` and `mem_wdata` hold their last driven values (registered mux).

Flush: `if_rvalid` = `pend` & ~`if_flush`. A flushed beat is lost and not replayed.

## Timing
- Reset (`rst`=0, async) clears: `pend`=0, `run`=0, `st_err`=0, `mem_addr`=0, `mem_wdata`=0. Outputs then read `if_gnt`=`st_gnt`=0, `if_rvalid`=0, `mem_en`=0, `mem_we`=0. `if_rdata` follows `mem_rdata` and is meaningful only with `if_rvalid`.
- Grants are combinational in the request cycle.
- Fetch latency is exactly one cycle: grant in cycle N gives `if_rvalid` and `if_rdata` in N+1.
- Back-to-back fetches give one word per cycle.
- A store granted in N is written at the N→N+1 edge. A fetch of the same address granted in N+1 returns the new data in N+2 (write-before-read across cycles, no bypass needed).
- Same-cycle fetch and store to one address: store wins; the fetch retries, waiting at most MAX_ST_BURST cycles.
- Reset asserted mid-fetch: `pend` clears immediately and no `if_rvalid` is produced after reset.
- Requesters hold request and payload stable until granted.

## Test plan
- Reset then fetch: `rst` low 3 cycles, preload RAM[5]=0x3c104000, `if_req`=1 with `if_addr`=0x3000_0005. Expect `if_gnt`=1 in N, `if_rvalid`=1 with `if_rdata`=0x3c104000 in N+1.
- Store then fetch: store 0xac620000 to 0x3000_0000 with `st_be`=4'hF, then fetch 0x3000_0000 one cycle later. Expect data 0xac620000.
- Contention with MAX_ST_BURST=4: `st_req` and `if_req` held high for 10 cycles. Expect the grant pattern S,S,S,S,F,S,S,S,S,F and `run` never above 4.
- Out-of-region store: store to 0x1000_0005. Expect `st_gnt`=1, `mem_we`=0, `st_err`=1 the next cycle, RAM unchanged.
- Flush: fetch granted in N, `if_flush`=1 in N+1. Expect `if_rvalid`=0 in N+1. A new fetch in N+1 returns valid data in N+2.
- Async reset mid-fetch: grant in N, `rst` falls mid-N. Expect `if_rvalid`=0 in N+1 and all outputs at their reset values.

Source files
------------

// File: rtl/imem_arbiter.sv
// Store/fetch arbiter for the single-ported instruction RAM.
// Stores win by default; a burst limiter lets a waiting fetch through after MAX_ST_BURST stores.
module imem_arbiter #(
    parameter int         ADDR_W       = 12,
    parameter logic [3:0] REGION       = 4'hC,
    parameter int         MAX_ST_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [29:0]       if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              st_req,
    input  logic [29:0]       st_addr,
    input  logic [31:0]       st_wdata,
    input  logic [3:0]        st_be,
    output logic              st_gnt,
    output logic              st_err,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    localparam logic [3:0] MAX_RUN = 4'(MAX_ST_BURST);

    logic              r_pend;
    logic              r_st_err;
    logic [3:0]        r_run;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    logic w_st_inreg;
    logic w_st_win;
    logic w_if_win;
    logic w_st_wr;
    logic w_unused_bits;

    // Grants are gated by reset so nothing reaches the RAM while rst is low.
    always_comb begin
        w_st_inreg = (st_addr[29:26] == REGION);
        w_st_win   = rst & st_req & (~if_req | (r_run != MAX_RUN));
        w_if_win   = rst & if_req & ~w_st_win;
        w_st_wr    = w_st_win & w_st_inreg;
    end

    assign w_unused_bits = ^{if_addr, st_addr};

    always_comb begin
        st_gnt    = w_st_win;
        if_gnt    = w_if_win;
        mem_en    = w_st_wr | w_if_win;
        mem_we    = w_st_wr ? st_be : 4'b0000;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        if (w_st_wr) begin
            mem_addr  = st_addr[ADDR_W-1:0];
            mem_wdata = st_wdata;
        end else if (w_if_win) begin
            mem_addr  = if_addr[ADDR_W-1:0];
        end
        if_rvalid = r_pend & ~if_flush;
        if_rdata  = mem_rdata;
        st_err    = r_st_err;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend   <= 1'b0;
            r_st_err <= 1'b0;
            r_run    <= 4'd0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            r_pend   <= w_if_win;
            r_st_err <= w_st_win & ~w_st_inreg;
            r_addr   <= mem_addr;
            r_wdata  <= mem_wdata;
            // run only counts stores that overtook a waiting fetch
            if (!if_req || w_if_win)
                r_run <= 4'd0;
            else if (w_st_win && (r_run != MAX_RUN))
                r_run <= r_run + 4'd1;
        end
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: vector table, directed corner sequences and a
// randomized run against a word-level model of grants, RAM contents and returns.
module tb_imem_arbiter;
    localparam int MAXB = 4;

    logic        clk, rst;
    logic        if_req, if_flush, if_gnt, if_rvalid;
    logic [29:0] if_addr, st_addr;
    logic [31:0] if_rdata, st_wdata, mem_wdata, mem_rdata;
    logic        st_req, st_gnt, st_err, mem_en;
    logic [3:0]  st_be, mem_we;
    logic [11:0] mem_addr;

    int n_chk = 0;
    int n_pass = 0;

    logic [31:0] ram       [0:4095];
    logic [31:0] model_mem [0:4095];

    imem_arbiter #(.ADDR_W(12), .REGION(4'hC), .MAX_ST_BURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .st_req(st_req), .st_addr(st_addr), .st_wdata(st_wdata), .st_be(st_be),
        .st_gnt(st_gnt), .st_err(st_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM with byte enables.
    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic preload();
        for (int i = 0; i < 4096; i++) begin
            ram[i]       <= 32'(i) * 32'h01010101 ^ 32'h5a5a0000;
            model_mem[i]  = 32'(i) * 32'h01010101 ^ 32'h5a5a0000;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        st_req = 1'b0; if_req = 1'b0; if_flush = 1'b0;
    endtask

    typedef struct {
        logic        st_req;
        logic        if_req;
        logic [29:0] st_addr;
        logic [3:0]  st_be;
        logic        e_st_gnt;
        logic        e_if_gnt;
        logic        e_mem_en;
        logic [3:0]  e_mem_we;
    } vec_t;

    vec_t tbl [6];

    // random-phase state
    logic        h_st, h_if, flush, exp_rv, fg, sg, inreg;
    logic [29:0] s_addr, f_addr;
    logic [31:0] s_data, m_pdata;
    logic [3:0]  s_be;
    logic        m_pend, m_err;
    int          m_streak;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 30'h30000020, 4'hF, 1'b1, 1'b0, 1'b1, 4'hF};
        tbl[1] = '{1'b1, 1'b0, 30'h10000020, 4'hF, 1'b1, 1'b0, 1'b0, 4'h0};
        tbl[2] = '{1'b0, 1'b1, 30'h30000020, 4'hF, 1'b0, 1'b1, 1'b1, 4'h0};
        tbl[3] = '{1'b1, 1'b1, 30'h30000022, 4'h3, 1'b1, 1'b0, 1'b1, 4'h3};
        tbl[4] = '{1'b1, 1'b0, 30'h30000023, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0};
        tbl[5] = '{1'b0, 1'b0, 30'h30000024, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0};

        rst = 1'b0; if_req = 1'b0; st_req = 1'b0; if_flush = 1'b0;
        if_addr = '0; st_addr = '0; st_wdata = '0; st_be = '0;
        preload();
        ram[5] <= 32'h3c104000; model_mem[5] = 32'h3c104000;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_if_gnt", 32'(if_gnt), 32'd0);
        chk("rst_st_gnt", 32'(st_gnt), 32'd0);
        chk("rst_rvalid", 32'(if_rvalid), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_st_err", 32'(st_err), 32'd0);
        rst = 1'b1;

        // reset then fetch
        @(negedge clk);
        if_req = 1'b1; if_addr = 30'h30000005;
        #1;
        chk("f1_gnt", 32'(if_gnt), 32'd1);
        chk("f1_mem_addr", 32'(mem_addr), 32'd5);
        chk("f1_mem_en", 32'(mem_en), 32'd1);
        idle(); #1;
        chk("f1_rvalid", 32'(if_rvalid), 32'd1);
        chk("f1_rdata", if_rdata, 32'h3c104000);

        // store then fetch same address
        @(negedge clk);
        st_req = 1'b1; st_addr = 30'h30000000; st_wdata = 32'hac620000; st_be = 4'hF;
        #1;
        chk("sf_st_gnt", 32'(st_gnt), 32'd1);
        chk("sf_mem_we", 32'(mem_we), 32'hF);
        chk("sf_mem_wdata", mem_wdata, 32'hac620000);
        model_mem[0] = 32'hac620000;
        @(negedge clk);
        st_req = 1'b0; if_req = 1'b1; if_addr = 30'h30000000;
        #1;
        chk("sf_if_gnt", 32'(if_gnt), 32'd1);
        idle(); #1;
        chk("sf_rvalid", 32'(if_rvalid), 32'd1);
        chk("sf_rdata", if_rdata, 32'hac620000);

        // idle holds last address and data
        chk("idle_mem_addr", 32'(mem_addr), 32'd0);
        chk("idle_mem_wdata", mem_wdata, 32'hac620000);

        // contention: S,S,S,S,F repeating
        @(negedge clk);
        st_req = 1'b1; st_addr = 30'h30000010; st_wdata = 32'h55aa55aa; st_be = 4'hF;
        if_req = 1'b1; if_addr = 30'h30000011;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk($sformatf("cont%0d_if_gnt", k), 32'(if_gnt), 32'((k % 5) == 4));
            chk($sformatf("cont%0d_st_gnt", k), 32'(st_gnt), 32'((k % 5) != 4));
        end
        idle();

        // out-of-region store, then read back addr 5
        @(negedge clk);
        st_req = 1'b1; st_addr = 30'h10000005; st_wdata = 32'hdeadbeef; st_be = 4'hF;
        #1;
        chk("oor_st_gnt", 32'(st_gnt), 32'd1);
        chk("oor_mem_we", 32'(mem_we), 32'd0);
        chk("oor_mem_en", 32'(mem_en), 32'd0);
        chk("oor_err_now", 32'(st_err), 32'd0);
        @(negedge clk);
        st_req = 1'b0; if_req = 1'b1; if_addr = 30'h30000005;
        #1;
        chk("oor_err_next", 32'(st_err), 32'd1);
        idle(); #1;
        chk("oor_err_clear", 32'(st_err), 32'd0);
        chk("oor_ram_kept", if_rdata, 32'h3c104000);

        // flush: beat from N is dropped, new fetch in N+1 returns in N+2
        @(negedge clk);
        if_req = 1'b1; if_addr = 30'h30000005;
        #1; chk("fl_gnt0", 32'(if_gnt), 32'd1);
        @(negedge clk);
        if_addr = 30'h30000000; if_flush = 1'b1;
        #1;
        chk("fl_rvalid_n1", 32'(if_rvalid), 32'd0);
        chk("fl_gnt1", 32'(if_gnt), 32'd1);
        idle(); #1;
        chk("fl_rvalid_n2", 32'(if_rvalid), 32'd1);
        chk("fl_rdata_n2", if_rdata, 32'hac620000);

        // single-cycle vector table, each from a clean idle state
        st_wdata = 32'h11223344; if_addr = 30'h30000021;
        foreach (tbl[i]) begin
            idle();
            @(negedge clk);
            st_req = tbl[i].st_req; if_req = tbl[i].if_req;
            st_addr = tbl[i].st_addr; st_be = tbl[i].st_be;
            #1;
            chk($sformatf("tbl%0d_st_gnt", i), 32'(st_gnt), 32'(tbl[i].e_st_gnt));
            chk($sformatf("tbl%0d_if_gnt", i), 32'(if_gnt), 32'(tbl[i].e_if_gnt));
            chk($sformatf("tbl%0d_mem_en", i), 32'(mem_en), 32'(tbl[i].e_mem_en));
            chk($sformatf("tbl%0d_mem_we", i), 32'(mem_we), 32'(tbl[i].e_mem_we));
        end
        idle(); idle();

        // randomized traffic against the model
        preload();
        h_st = 1'b0; h_if = 1'b0; m_pend = 1'b0; m_err = 1'b0; m_streak = 0;
        s_addr = '0; f_addr = '0; s_data = '0; s_be = '0; m_pdata = '0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (!h_st && $urandom_range(0, 2) != 0) begin
                h_st   = 1'b1;
                s_addr = (($urandom_range(0, 5) == 0) ? 30'h10000000 : 30'h30000000)
                         | 30'($urandom_range(0, 15));
                s_data = $urandom;
                s_be   = 4'($urandom_range(0, 15));
            end
            if (!h_if && $urandom_range(0, 2) != 0) begin
                h_if   = 1'b1;
                f_addr = 30'h30000000 | 30'($urandom_range(0, 15));
            end
            flush = ($urandom_range(0, 7) == 0);
            st_req = h_st; st_addr = s_addr; st_wdata = s_data; st_be = s_be;
            if_req = h_if; if_addr = f_addr; if_flush = flush;
            #1;
            exp_rv = m_pend & ~flush;
            chk("rnd_rvalid", 32'(if_rvalid), 32'(exp_rv));
            if (exp_rv) chk("rnd_rdata", if_rdata, m_pdata);
            chk("rnd_st_err", 32'(st_err), 32'(m_err));
            inreg = (s_addr[29:26] == 4'hC);
            fg = h_if && (!h_st || m_streak == MAXB);
            sg = h_st && !fg;
            chk("rnd_if_gnt", 32'(if_gnt), 32'(fg));
            chk("rnd_st_gnt", 32'(st_gnt), 32'(sg));
            chk("rnd_mem_en", 32'(mem_en), 32'((sg && inreg) || fg));
            chk("rnd_mem_we", 32'(mem_we), (sg && inreg) ? 32'(s_be) : 32'd0);
            if (fg) chk("rnd_f_addr", 32'(mem_addr), 32'(f_addr[11:0]));
            if (sg && inreg) begin
                chk("rnd_s_addr", 32'(mem_addr), 32'(s_addr[11:0]));
                for (int b = 0; b < 4; b++)
                    if (s_be[b]) model_mem[s_addr[11:0]][8*b +: 8] = s_data[8*b +: 8];
            end
            m_err  = sg && !inreg;
            m_pend = fg;
            if (fg) m_pdata = model_mem[f_addr[11:0]];
            // consecutive stores served while a fetch sat waiting
            if (!h_if || fg) m_streak = 0;
            else if (sg && m_streak < MAXB) m_streak++;
            if (sg) h_st = 1'b0;
            if (fg) h_if = 1'b0;
        end
        idle(); idle();

        // async reset in the middle of a fetch grant cycle
        @(negedge clk);
        if_req = 1'b1; if_addr = 30'h30000005;
        #1; chk("ar_gnt", 32'(if_gnt), 32'd1);
        #2; rst = 1'b0;
        #1;
        chk("ar_if_gnt", 32'(if_gnt), 32'd0);
        chk("ar_mem_en", 32'(mem_en), 32'd0);
        chk("ar_mem_addr", 32'(mem_addr), 32'd0);
        chk("ar_mem_wdata", mem_wdata, 32'd0);
        chk("ar_rvalid_now", 32'(if_rvalid), 32'd0);
        @(negedge clk);
        if_req = 1'b0; rst = 1'b1;
        #1;
        chk("ar_rvalid_next", 32'(if_rvalid), 32'd0);
        chk("ar_st_err", 32'(st_err), 32'd0);
        idle(); #1;
        chk("ar_rvalid_late", 32'(if_rvalid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
